// File: rtl/turn_ram_controller_pkg.sv
// Shared definitions for the spy-code turn controller: state codes, player
// region bases and region depth.
package game_pkg;

  localparam int HALF_DEPTH = 16;
  localparam int P1_BASE    = 0;
  localparam int P2_BASE    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_P1     = 3'd1,
    ST_P2     = 3'd2,
    ST_CMP    = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  // Compare sub-phases: one length check, then three cycles per word index.
  typedef enum logic [1:0] {
    PH_CHK = 2'd0,
    PH_C0  = 2'd1,
    PH_C1  = 2'd2,
    PH_C2  = 2'd3
  } cmp_phase_t;

endpackage

// File: rtl/region_counter.sv
// Per-player word counter: saturating length, full flag and the next free
// RAM address (region base + length).
module region_counter
  import game_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = HALF_DEPTH,
  parameter int BASE   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_len,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] r_len;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_len <= '0;
    end else if (i_inc && !o_full) begin
      r_len <= r_len + ADDR_W'(1);
    end
  end

  assign o_len  = r_len;
  assign o_full = (r_len == ADDR_W'(DEPTH));
  assign o_addr = ADDR_W'(BASE) + r_len;

endmodule

// File: rtl/turn_ram_controller.sv
// Spy-code round sequencer and single-port code RAM arbiter.
// Optional turn timeout is built only when TIMEOUT_EN is defined.
module turn_ram_controller #(
  parameter int DATA_W     = 20,
  parameter int ADDR_W     = 5,
  parameter int HALF_DEPTH = 16,
  parameter int TURN_TICKS = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              tick,
  input  logic              p1_wr_req,
  input  logic [DATA_W-1:0] p1_wr_data,
  input  logic              p1_done,
  input  logic              p2_wr_req,
  input  logic [DATA_W-1:0] p2_wr_data,
  input  logic              p2_done,
  output logic              wr_ack,
  output logic              full,
  input  logic              vga_rd_req,
  input  logic [ADDR_W-1:0] vga_rd_addr,
  output logic              vga_rd_ack,
  output logic              vga_rd_valid,
  output logic [DATA_W-1:0] vga_rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [2:0]        state,
  output logic [ADDR_W-1:0] p1_len,
  output logic [ADDR_W-1:0] p2_len,
  output logic              result_valid,
  output logic              match
);
  import game_pkg::*;

  localparam logic [ADDR_W-1:0] P1_ADDR = ADDR_W'(P1_BASE);
  localparam logic [ADDR_W-1:0] P2_ADDR = ADDR_W'(P2_BASE);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  state_t            r_state, w_nextState;
  cmp_phase_t        r_phase, w_nextPhase;
  logic [ADDR_W-1:0] r_cmpIdx, w_nextIdx;
  logic [DATA_W-1:0] r_p1Word;
  logic              r_match, w_nextMatch;
  logic              r_vgaValid;
  logic              w_clearLens, w_timeout, w_p1Done, w_p2Done;
  logic              w_p1Write, w_p2Write, w_p1Full, w_p2Full, w_vgaGrant;
  logic [ADDR_W-1:0] w_p1Len, w_p2Len, w_p1Addr, w_p2Addr;

  region_counter #(.ADDR_W(ADDR_W), .DEPTH(HALF_DEPTH), .BASE(P1_BASE)) u_p1Region (
    .clock(clock), .reset(reset), .i_clear(w_clearLens), .i_inc(w_p1Write),
    .o_len(w_p1Len), .o_full(w_p1Full), .o_addr(w_p1Addr)
  );

  region_counter #(.ADDR_W(ADDR_W), .DEPTH(HALF_DEPTH), .BASE(P2_BASE)) u_p2Region (
    .clock(clock), .reset(reset), .i_clear(w_clearLens), .i_inc(w_p2Write),
    .o_len(w_p2Len), .o_full(w_p2Full), .o_addr(w_p2Addr)
  );

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TURN_TICKS + 1);
  logic [TW-1:0] r_tickCount;

  // Any state change restarts the count, so each turn starts from zero.
  always_ff @(posedge clock) begin
    if (reset || (r_state != w_nextState)) begin
      r_tickCount <= '0;
    end else if (tick && (r_tickCount != TW'(TURN_TICKS))) begin
      r_tickCount <= r_tickCount + TW'(1);
    end
  end

  assign w_timeout = (r_tickCount == TW'(TURN_TICKS));
`else
  logic w_unusedTick;
  assign w_unusedTick = tick;
  assign w_timeout    = 1'b0;
`endif

  assign w_p1Write = (r_state == ST_P1) && p1_wr_req && !w_p1Full;
  assign w_p2Write = (r_state == ST_P2) && p2_wr_req && !w_p2Full;
  assign w_p1Done  = p1_done || w_timeout;
  assign w_p2Done  = p2_done || w_timeout;

  always_comb begin
    w_nextState = r_state;
    w_nextPhase = r_phase;
    w_nextIdx   = r_cmpIdx;
    w_nextMatch = r_match;
    w_clearLens = 1'b0;
    case (r_state)
      ST_IDLE, ST_RESULT: begin
        if (start) begin
          w_nextState = ST_P1;
          w_nextMatch = 1'b0;
          w_clearLens = 1'b1;
        end
      end
      ST_P1: begin
        if (w_p1Done) begin
          if ((w_p1Len != '0) || w_p1Write) w_nextState = ST_P2;
          else if (w_timeout)               w_nextState = ST_IDLE;
        end
      end
      ST_P2: begin
        if (w_p2Done) begin
          w_nextState = ST_CMP;
          w_nextPhase = PH_CHK;
          w_nextIdx   = '0;
        end
      end
      ST_CMP: begin
        case (r_phase)
          PH_CHK: begin
            if (w_p1Len != w_p2Len) begin
              w_nextState = ST_RESULT;
              w_nextMatch = 1'b0;
            end else if (w_p1Len == '0) begin
              w_nextState = ST_RESULT;
              w_nextMatch = 1'b1;
            end else begin
              w_nextPhase = PH_C0;
            end
          end
          PH_C0: w_nextPhase = PH_C1;
          PH_C1: w_nextPhase = PH_C2;
          PH_C2: begin
            if (r_p1Word != ram_rdata) begin
              w_nextState = ST_RESULT;
              w_nextMatch = 1'b0;
            end else if (r_cmpIdx == (w_p1Len - ONE)) begin
              w_nextState = ST_RESULT;
              w_nextMatch = 1'b1;
            end else begin
              w_nextIdx   = r_cmpIdx + ONE;
              w_nextPhase = PH_C0;
            end
          end
          default: w_nextPhase = PH_CHK;
        endcase
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // RAM port owner: player write, then compare engine, then VGA read-back.
  always_comb begin
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_wren   = 1'b0;
    wr_ack     = 1'b0;
    w_vgaGrant = 1'b0;
    if (!reset) begin
      if (w_p1Write) begin
        ram_addr  = w_p1Addr;
        ram_wdata = p1_wr_data;
        ram_wren  = 1'b1;
        wr_ack    = 1'b1;
      end else if (w_p2Write) begin
        ram_addr  = w_p2Addr;
        ram_wdata = p2_wr_data;
        ram_wren  = 1'b1;
        wr_ack    = 1'b1;
      end else if (r_state == ST_CMP) begin
        if (r_phase == PH_C0)      ram_addr = P1_ADDR + r_cmpIdx;
        else if (r_phase == PH_C1) ram_addr = P2_ADDR + r_cmpIdx;
      end else if (vga_rd_req) begin
        w_vgaGrant = 1'b1;
        ram_addr   = vga_rd_addr;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_phase    <= PH_CHK;
      r_cmpIdx   <= '0;
      r_p1Word   <= '0;
      r_match    <= 1'b0;
      r_vgaValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_phase    <= w_nextPhase;
      r_cmpIdx   <= w_nextIdx;
      r_match    <= w_nextMatch;
      r_vgaValid <= w_vgaGrant;
      if ((r_state == ST_CMP) && (r_phase == PH_C1)) r_p1Word <= ram_rdata;
    end
  end

  assign full = (r_state == ST_P1) ? w_p1Full :
                (r_state == ST_P2) ? w_p2Full : 1'b0;

  assign vga_rd_ack   = w_vgaGrant;
  assign vga_rd_valid = r_vgaValid;
  assign vga_rd_data  = r_vgaValid ? ram_rdata : '0;
  assign state        = r_state;
  assign p1_len       = w_p1Len;
  assign p2_len       = w_p2Len;
  assign result_valid = (r_state == ST_RESULT);
  assign match        = r_match;

endmodule

// File: tb/tb_turn_ram_controller.sv
// Directed self-checking bench for turn_ram_controller with a behavioural
// single-port RAM (1-cycle read latency) attached to the RAM port.
module tb_turn_ram_controller;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 5;
`ifdef TIMEOUT_EN
  localparam int STATE_AFTER_TICKS = 2;
`else
  localparam int STATE_AFTER_TICKS = 1;
`endif

  logic              clock = 1'b0;
  logic              reset, start, tick;
  logic              p1_wr_req, p1_done, p2_wr_req, p2_done;
  logic [DATA_W-1:0] p1_wr_data, p2_wr_data;
  logic              wr_ack, full;
  logic              vga_rd_req, vga_rd_ack, vga_rd_valid;
  logic [ADDR_W-1:0] vga_rd_addr;
  logic [DATA_W-1:0] vga_rd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              ram_wren;
  logic [2:0]        state;
  logic [ADDR_W-1:0] p1_len, p2_len;
  logic              result_valid, match;

  logic [DATA_W-1:0] mem [32];
  int checks = 0;
  int errors = 0;
  int cycles;

  always #5 clock = ~clock;

  turn_ram_controller dut (
    .clock(clock), .reset(reset), .start(start), .tick(tick),
    .p1_wr_req(p1_wr_req), .p1_wr_data(p1_wr_data), .p1_done(p1_done),
    .p2_wr_req(p2_wr_req), .p2_wr_data(p2_wr_data), .p2_done(p2_done),
    .wr_ack(wr_ack), .full(full),
    .vga_rd_req(vga_rd_req), .vga_rd_addr(vga_rd_addr), .vga_rd_ack(vga_rd_ack),
    .vga_rd_valid(vga_rd_valid), .vga_rd_data(vga_rd_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_rdata(ram_rdata),
    .state(state), .p1_len(p1_len), .p2_len(p2_len),
    .result_valid(result_valid), .match(match)
  );

  always @(posedge clock) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int player, input logic [DATA_W-1:0] data, input logic expAck,
                               input logic [ADDR_W-1:0] expAddr, input string tag);
    if (player == 1) begin
      p1_wr_req = 1'b1; p1_wr_data = data;
    end else begin
      p2_wr_req = 1'b1; p2_wr_data = data;
    end
    #1;
    checkOutput({tag, " ack"}, 32'(wr_ack), 32'(expAck));
    if (expAck) checkOutput({tag, " addr"}, 32'(ram_addr), 32'(expAddr));
    stepCycle();
    p1_wr_req = 1'b0;
    p2_wr_req = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1; stepCycle(); start = 1'b0;
  endtask

  task automatic pulseDone(input int player);
    if (player == 1) p1_done = 1'b1; else p2_done = 1'b1;
    stepCycle();
    p1_done = 1'b0; p2_done = 1'b0;
  endtask

  task automatic waitResult(output int n);
    n = 0;
    while (result_valid !== 1'b1 && n < 60) begin
      stepCycle();
      n++;
    end
    checkOutput("result_valid reached", 32'(result_valid), 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tick = 1'b0;
    p1_wr_req = 1'b0; p1_wr_data = '0; p1_done = 1'b0;
    p2_wr_req = 1'b0; p2_wr_data = '0; p2_done = 1'b0;
    vga_rd_req = 1'b0; vga_rd_addr = '0;
    repeat (3) stepCycle();
    reset = 1'b0;
    #1;
    checkOutput("reset state", 32'(state), 0);
    checkOutput("reset p1_len", 32'(p1_len), 0);
    checkOutput("reset p2_len", 32'(p2_len), 0);
    checkOutput("reset match", 32'(match), 0);
    checkOutput("reset result_valid", 32'(result_valid), 0);
    checkOutput("reset wr_ack", 32'(wr_ack), 0);
    checkOutput("reset vga_rd_ack", 32'(vga_rd_ack), 0);
    checkOutput("reset vga_rd_valid", 32'(vga_rd_valid), 0);
    checkOutput("reset ram_wren", 32'(ram_wren), 0);
    checkOutput("reset ram_addr", 32'(ram_addr), 0);

    // Round 1: three matching words
    pulseStart();
    checkOutput("r1 enter P1", 32'(state), 1);
    pulseDone(1);
    checkOutput("r1 empty p1_done ignored", 32'(state), 1);
    p2_wr_req = 1'b1; p2_wr_data = 20'h00055;
    #1;
    checkOutput("r1 p2 req ignored in P1", 32'(wr_ack), 0);
    stepCycle();
    p2_wr_req = 1'b0;
    checkOutput("r1 p2_len in P1", 32'(p2_len), 0);
    applyStimulus(1, 20'h0000A, 1'b1, 5'd0, "r1 p1 w0");
    applyStimulus(1, 20'h00005, 1'b1, 5'd1, "r1 p1 w1");
    applyStimulus(1, 20'h7FFFF, 1'b1, 5'd2, "r1 p1 w2");
    checkOutput("r1 p1_len", 32'(p1_len), 3);
    pulseDone(1);
    checkOutput("r1 enter P2", 32'(state), 2);
    applyStimulus(2, 20'h0000A, 1'b1, 5'd16, "r1 p2 w0");
    applyStimulus(2, 20'h00005, 1'b1, 5'd17, "r1 p2 w1");
    applyStimulus(2, 20'h7FFFF, 1'b1, 5'd18, "r1 p2 w2");
    pulseDone(2);
    checkOutput("r1 enter CMP", 32'(state), 3);
    vga_rd_req = 1'b1; vga_rd_addr = 5'd0;
    #1;
    checkOutput("r1 vga blocked in CMP", 32'(vga_rd_ack), 0);
    vga_rd_req = 1'b0;
    waitResult(cycles);
    checkOutput("r1 cmp latency", 32'(cycles), 10);
    checkOutput("r1 match", 32'(match), 1);
    checkOutput("r1 state RESULT", 32'(state), 4);
    checkOutput("r1 ram[0]", 32'(mem[0]), 32'h0000A);
    checkOutput("r1 ram[2]", 32'(mem[2]), 32'h7FFFF);
    checkOutput("r1 ram[16]", 32'(mem[16]), 32'h0000A);
    checkOutput("r1 ram[18]", 32'(mem[18]), 32'h7FFFF);
    vga_rd_req = 1'b1; vga_rd_addr = 5'd17;
    #1;
    checkOutput("r1 vga ack in RESULT", 32'(vga_rd_ack), 1);
    checkOutput("r1 vga addr", 32'(ram_addr), 17);
    stepCycle();
    vga_rd_req = 1'b0;
    #1;
    checkOutput("r1 vga valid", 32'(vga_rd_valid), 1);
    checkOutput("r1 vga data", 32'(vga_rd_data), 32'h00005);

    // Round 2: equal length, mismatch on index 1
    pulseStart();
    checkOutput("r2 enter P1", 32'(state), 1);
    checkOutput("r2 p1_len cleared", 32'(p1_len), 0);
    checkOutput("r2 p2_len cleared", 32'(p2_len), 0);
    checkOutput("r2 match cleared", 32'(match), 0);
    checkOutput("r2 result_valid cleared", 32'(result_valid), 0);
    applyStimulus(1, 20'd1, 1'b1, 5'd0, "r2 p1 w0");
    applyStimulus(1, 20'd2, 1'b1, 5'd1, "r2 p1 w1");
    pulseDone(1);
    applyStimulus(2, 20'd1, 1'b1, 5'd16, "r2 p2 w0");
    applyStimulus(2, 20'd3, 1'b1, 5'd17, "r2 p2 w1");
    pulseDone(2);
    waitResult(cycles);
    checkOutput("r2 cmp latency", 32'(cycles), 7);
    checkOutput("r2 match", 32'(match), 0);

    // Round 3: length mismatch
    pulseStart();
    applyStimulus(1, 20'h00011, 1'b1, 5'd0, "r3 p1 w0");
    applyStimulus(1, 20'h00022, 1'b1, 5'd1, "r3 p1 w1");
    pulseDone(1);
    pulseDone(2);
    checkOutput("r3 enter CMP", 32'(state), 3);
    waitResult(cycles);
    checkOutput("r3 cmp latency", 32'(cycles), 1);
    checkOutput("r3 match", 32'(match), 0);

    // Round 4: VGA arbitration during a write burst, then fill P1 region
    pulseStart();
    vga_rd_req = 1'b1; vga_rd_addr = 5'd17;
    p1_wr_req = 1'b1; p1_wr_data = 20'h00100;
    #1;
    checkOutput("r4 write beats vga ack", 32'(wr_ack), 1);
    checkOutput("r4 vga not granted", 32'(vga_rd_ack), 0);
    stepCycle();
    p1_wr_req = 1'b0;
    #1;
    checkOutput("r4 vga granted idle", 32'(vga_rd_ack), 1);
    checkOutput("r4 vga addr", 32'(ram_addr), 17);
    checkOutput("r4 vga valid before", 32'(vga_rd_valid), 0);
    stepCycle();
    p1_wr_req = 1'b1; p1_wr_data = 20'h00101;
    #1;
    checkOutput("r4 write addr", 32'(ram_addr), 1);
    checkOutput("r4 vga not granted 2", 32'(vga_rd_ack), 0);
    checkOutput("r4 vga valid", 32'(vga_rd_valid), 1);
    checkOutput("r4 vga data", 32'(vga_rd_data), 32'h00003);
    stepCycle();
    p1_wr_req = 1'b0; vga_rd_req = 1'b0;
    #1;
    checkOutput("r4 vga valid drops", 32'(vga_rd_valid), 0);
    for (int i = 2; i < 16; i++) applyStimulus(1, 20'(256 + i), 1'b1, 5'(i), "r4 fill");
    checkOutput("r4 full", 32'(full), 1);
    checkOutput("r4 p1_len 16", 32'(p1_len), 16);
    applyStimulus(1, 20'hDEAD0, 1'b0, 5'd0, "r4 overflow");
    checkOutput("r4 p1_len sat", 32'(p1_len), 16);
    checkOutput("r4 ram[16] untouched", 32'(mem[16]), 32'h00001);
    checkOutput("r4 ram[15]", 32'(mem[15]), 32'h0010F);

    // Reset in the middle of a long compare
    pulseDone(1);
    for (int i = 0; i < 16; i++) applyStimulus(2, 20'(256 + i), 1'b1, 5'(16 + i), "r4 p2 fill");
    checkOutput("r4 p2 full", 32'(full), 1);
    pulseDone(2);
    repeat (5) stepCycle();
    checkOutput("r4 still CMP", 32'(state), 3);
    reset = 1'b1;
    stepCycle();
    checkOutput("mid reset state", 32'(state), 0);
    checkOutput("mid reset p1_len", 32'(p1_len), 0);
    checkOutput("mid reset p2_len", 32'(p2_len), 0);
    checkOutput("mid reset match", 32'(match), 0);
    checkOutput("mid reset result_valid", 32'(result_valid), 0);
    checkOutput("mid reset ram_wren", 32'(ram_wren), 0);
    reset = 1'b0;
    stepCycle();

    // Turn timeout (P1 with one word); ticks are ignored in the default build
    pulseStart();
    applyStimulus(1, 20'h12345, 1'b1, 5'd0, "to p1 w0");
    repeat (30) begin
      tick = 1'b1; stepCycle();
      tick = 1'b0; stepCycle();
    end
    stepCycle();
    checkOutput("timeout state", 32'(state), 32'(STATE_AFTER_TICKS));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
